// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: 8N1 serial packets drive single 32-bit bus reads/writes, reply on txd.
// Optional build macro UART_BRIDGE_TIMEOUT_EN aborts a stalled partial packet with a NAK.
module uart_bus_bridge #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    output logic        bus_de,
    output logic [31:0] bus_addr,
    output logic [1:0]  bus_drw,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_stall,
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;
    localparam logic [2:0] P_OP    = 3'd0;
    localparam logic [2:0] P_ADDR  = 3'd1;
    localparam logic [2:0] P_WDATA = 3'd2;
    localparam logic [2:0] P_BUS   = 3'd3;
    localparam logic [2:0] P_REPLY = 3'd4;
    logic          rx_s1, rx_s2, rx_q;
    logic [1:0]    rx_st;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          byte_valid, frame_err;
    logic [9:0]    tx_sh;
    logic [3:0]    tx_left;
    logic [CW-1:0] tx_cnt;
    logic          tx_go, tx_ready;
    logic [2:0]    st;
    logic          is_wr;
    logic [2:0]    cnt;
    logic [31:0]   rep_sh;
    logic [2:0]    rep_left;
    logic          to_hit;
    assign busy     = st != P_OP;
    assign txd      = (tx_left == 4'd0) | tx_sh[0];
    assign tx_ready = (tx_left == 4'd0) | ((tx_left == 4'd1) & (tx_cnt == BIT_END));
    assign tx_go    = (st == P_REPLY) & (rep_left != 3'd0) & tx_ready;
    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end
    // receiver: half-bit start check, mid-bit sampling, stop bit decides valid vs framing error
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_st      <= R_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_sh      <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_st)
                R_IDLE: if (rx_q && !rx_s2) begin
                    rx_st  <= R_START;
                    rx_cnt <= '0;
                end
                R_START: if (rx_cnt == HALF_END) begin
                    rx_cnt <= '0;
                    rx_bit <= 3'd0;
                    rx_st  <= rx_s2 ? R_IDLE : R_DATA;
                end else rx_cnt <= rx_cnt + 1'b1;
                R_DATA: if (rx_cnt == BIT_END) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_st <= R_STOP;
                end else rx_cnt <= rx_cnt + 1'b1;
                default: if (rx_cnt == BIT_END) begin
                    rx_cnt     <= '0;
                    rx_st      <= R_IDLE;
                    byte_valid <= rx_s2;
                    frame_err  <= !rx_s2;
                end else rx_cnt <= rx_cnt + 1'b1;
            endcase
        end
    end
    // transmitter: 10-bit frame shifted out LSB first; reloads on the edge the stop bit ends
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_sh   <= '1;
            tx_left <= 4'd0;
            tx_cnt  <= '0;
        end else if (tx_go) begin
            tx_sh   <= {1'b1, rep_sh[31:24], 1'b0};
            tx_left <= 4'd10;
            tx_cnt  <= '0;
        end else if (tx_left != 4'd0) begin
            if (tx_cnt == BIT_END) begin
                tx_cnt  <= '0;
                tx_sh   <= {1'b1, tx_sh[9:1]};
                tx_left <= tx_left - 4'd1;
            end else tx_cnt <= tx_cnt + 1'b1;
        end
    end
`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    // inter-byte idle counter, only live while collecting address or data bytes
    always_ff @(posedge clk) begin
        if (!rst || byte_valid || !(st == P_ADDR || st == P_WDATA)) to_cnt <= '0;
        else to_cnt <= to_cnt + 1'b1;
    end
    assign to_hit = to_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    // no abort: a partial packet waits forever (expression is constant false)
    assign to_hit = TIMEOUT_CYCLES < 0;
`endif
    // packet FSM: decode opcode, collect address/data, run one bus cycle, queue the reply
    always_ff @(posedge clk) begin
        if (!rst) begin
            st        <= P_OP;
            is_wr     <= 1'b0;
            cnt       <= 3'd0;
            bus_de    <= 1'b0;
            bus_drw   <= 2'b00;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            rep_sh    <= 32'd0;
            rep_left  <= 3'd0;
        end else begin
            case (st)
                P_OP: if (byte_valid) begin
                    cnt   <= 3'd4;
                    is_wr <= rx_sh == 8'h57;
                    if (rx_sh == 8'h57 || rx_sh == 8'h52) st <= P_ADDR;
                    else begin
                        rep_sh   <= {8'h15, 24'd0};
                        rep_left <= 3'd1;
                        st       <= P_REPLY;
                    end
                end
                P_ADDR: if (frame_err) st <= P_OP;
                else if (byte_valid) begin
                    bus_addr <= {bus_addr[23:0], rx_sh};
                    cnt      <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (is_wr) begin
                            cnt <= 3'd4;
                            st  <= P_WDATA;
                        end else begin
                            bus_de  <= 1'b1;
                            bus_drw <= 2'b10;
                            st      <= P_BUS;
                        end
                    end
                end else if (to_hit) begin
                    rep_sh   <= {8'h15, 24'd0};
                    rep_left <= 3'd1;
                    st       <= P_REPLY;
                end
                P_WDATA: if (frame_err) st <= P_OP;
                else if (byte_valid) begin
                    bus_wdata <= {bus_wdata[23:0], rx_sh};
                    cnt       <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        bus_de  <= 1'b1;
                        bus_drw <= 2'b01;
                        st      <= P_BUS;
                    end
                end else if (to_hit) begin
                    rep_sh   <= {8'h15, 24'd0};
                    rep_left <= 3'd1;
                    st       <= P_REPLY;
                end
                P_BUS: if (!bus_stall) begin
                    bus_de   <= 1'b0;
                    bus_drw  <= 2'b00;
                    rep_sh   <= is_wr ? {8'h06, 24'd0} : bus_rdata;
                    rep_left <= is_wr ? 3'd1 : 3'd4;
                    st       <= P_REPLY;
                end
                P_REPLY: if (tx_go) begin
                    rep_sh   <= {rep_sh[23:0], 8'd0};
                    rep_left <= rep_left - 3'd1;
                end else if (rep_left == 3'd0 && tx_ready) st <= P_OP;
                default: st <= P_OP;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed packets over rxd, decoded replies on txd, bus cycles monitored.
module tb_uart_bus_bridge;
    localparam int CPB = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic        bus_stall = 1'b0;
    logic [31:0] bus_rdata = 32'h12345678;
    logic        txd, bus_de, busy;
    logic [31:0] bus_addr, bus_wdata;
    logic [1:0]  bus_drw;
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  rq[$];
    int          rp = 0;
    int          de_cnt = 0;
    int          de_run = 0;
    logic        stall_en = 1'b0;
    logic [1:0]  l_drw = 2'b00;
    logic [31:0] l_addr = 32'd0;
    logic [31:0] l_wdata = 32'd0;
    int          d0;
    logic [8:0]  v;

    uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(400)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .bus_de(bus_de), .bus_addr(bus_addr),
        .bus_drw(bus_drw), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_stall(bus_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // bus slave model: counts request cycles, stalls the first three when enabled
    always @(negedge clk) begin
        if (bus_de) begin
            de_cnt++;
            de_run++;
            l_drw   = bus_drw;
            l_addr  = bus_addr;
            l_wdata = bus_wdata;
        end else de_run = 0;
        bus_stall = stall_en && bus_de && de_run <= 3;
    end

    // serial decoder for txd: pushes {stop, data}
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                rq.push_back({txd, b});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_reply(input int n, input string tag);
        int t = 0;
        while (rq.size() - rp < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk(tag, 64'(rq.size() - rp), 64'(n));
    endtask

    task automatic take(output logic [8:0] r);
        if (rp < rq.size()) begin
            r = rq[rp];
            rp++;
        end else r = 'x;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_de", bus_de, 0);
        chk("rst_drw", bus_drw, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        d0 = de_cnt;
        send_byte(8'h57, 1'b1);
        send4(32'h00001000);
        chk("w_busy", busy, 1);
        send4(32'hDEADBEEF);
        wait_reply(1, "w_tmo");
        take(v);
        chk("w_ack", v, 9'h106);
        chk("w_de_cycles", 64'(de_cnt - d0), 1);
        chk("w_drw", l_drw, 2'b01);
        chk("w_addr", l_addr, 32'h00001000);
        chk("w_wdata", l_wdata, 32'hDEADBEEF);
        repeat (2 * CPB) @(negedge clk);
        chk("w_busy_end", busy, 0);

        stall_en = 1'b1;
        d0 = de_cnt;
        send_byte(8'h52, 1'b1);
        send4(32'h80000004);
        wait_reply(4, "r_tmo");
        take(v); chk("r_b0", v, 9'h112);
        take(v); chk("r_b1", v, 9'h134);
        take(v); chk("r_b2", v, 9'h156);
        take(v); chk("r_b3", v, 9'h178);
        chk("r_de_cycles", 64'(de_cnt - d0), 4);
        chk("r_drw", l_drw, 2'b10);
        chk("r_addr", l_addr, 32'h80000004);
        stall_en = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        d0 = de_cnt;
        send_byte(8'h41, 1'b1);
        wait_reply(1, "nak_tmo");
        take(v);
        chk("nak", v, 9'h115);
        chk("nak_no_bus", 64'(de_cnt - d0), 0);
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h57, 1'b1);
        send4(32'h00000020);
        send4(32'h01020304);
        wait_reply(1, "w2_tmo");
        take(v);
        chk("w2_ack", v, 9'h106);
        chk("w2_addr", l_addr, 32'h00000020);
        chk("w2_wdata", l_wdata, 32'h01020304);
        repeat (2 * CPB) @(negedge clk);

        d0 = de_cnt;
        send_byte(8'h57, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (200) @(negedge clk);
        chk("fe_no_reply", 64'(rq.size() - rp), 0);
        chk("fe_no_bus", 64'(de_cnt - d0), 0);
        chk("fe_idle", busy, 0);
        send_byte(8'h52, 1'b1);
        send4(32'h00000008);
        wait_reply(4, "fe_next_tmo");
        take(v); chk("fe_next_b0", v, 9'h112);
        take(v); take(v); take(v);
        chk("fe_next_b3", v, 9'h178);
        chk("fe_next_addr", l_addr, 32'h00000008);
        repeat (2 * CPB) @(negedge clk);

        send_byte(8'h52, 1'b1);
        send4(32'h0000000C);
        begin
            int t = 0;
            while (txd !== 1'b0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) chk("mr_start_tmo", txd, 0);
        end
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_txd", txd, 1);
        chk("mr_busy", busy, 0);
        chk("mr_de", bus_de, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (120) @(negedge clk);
        rp = rq.size();
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (150) @(negedge clk);
        chk("glitch_no_reply", 64'(rq.size() - rp), 0);
        chk("glitch_idle", busy, 0);

        d0 = de_cnt;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef UART_BRIDGE_TIMEOUT_EN
        wait_reply(1, "to_tmo");
        take(v);
        chk("to_nak", v, 9'h115);
        chk("to_no_bus", 64'(de_cnt - d0), 0);
        repeat (2 * CPB) @(negedge clk);
        chk("to_idle", busy, 0);
`else
        repeat (600) @(negedge clk);
        chk("to_no_reply", 64'(rq.size() - rp), 0);
        chk("to_no_bus", 64'(de_cnt - d0), 0);
        chk("to_busy", busy, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
